// File: rtl/clk_rate_ctrl_pkg.sv
// Shared types and divide table for the clock-enable rate controller.
// Rate codes index DIV_TABLE; div_of() gives the terminal count (DIV-1).
package clk_rate_pkg;

   localparam int unsigned DIV_M1_W = 6;

   typedef enum logic [1:0] {
      RATE_1M,
      RATE_10M,
      RATE_25M,
      RATE_50M
   } rate_code_t;

   typedef enum logic {
      RUN,
      PEND
   } state_t;

   // Divide ratio from the 50 MHz system clock, indexed by rate code.
   localparam int unsigned DIV_TABLE [4] = '{50, 5, 2, 1};

   function automatic logic [DIV_M1_W-1:0] div_of(rate_code_t code);
      return DIV_M1_W'(DIV_TABLE[int'(code)] - 1);
   endfunction

endpackage

// File: rtl/clk_rate_ctrl_if.sv
// Request/status bundle between the rate controller and its user.
// master drives the request side, slave is the controller.
interface clk_rate_ctrl_if
   import clk_rate_pkg::*;
#(
   parameter int unsigned TCNT_W = 16
);

   logic              en;
   logic              sel_req;
   rate_code_t        sel_code;
   logic              sel_ack;
   logic              busy;
   rate_code_t        rate_code;
   logic              tick;
   logic [TCNT_W-1:0] tick_count;

   modport master (
      output en,
      output sel_req,
      output sel_code,
      input  sel_ack,
      input  busy,
      input  rate_code,
      input  tick,
      input  tick_count
   );

   modport slave (
      input  en,
      input  sel_req,
      input  sel_code,
      output sel_ack,
      output busy,
      output rate_code,
      output tick,
      output tick_count
   );

endinterface

// File: rtl/clk_rate_ctrl_tick_gen.sv
// Period counter and registered tick pulse with a wrapping tick counter.
// at_end flags the enabled edge that closes the current period.
module tick_gen #(
   parameter int unsigned CNT_W  = 6,
   parameter int unsigned TCNT_W = 16
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic [CNT_W-1:0]  div_m1,
   output logic              at_end,
   output logic              tick,
   output logic [TCNT_W-1:0] tick_count
);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tick_q, tick_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;

   always_comb begin
      at_end = en && (cnt_q == div_m1);
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      tcnt_d = tcnt_q;
      if (load || at_end) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (at_end) begin
         tick_d = 1'b1;
         tcnt_d = tcnt_q + TCNT_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         tcnt_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         tcnt_q <= tcnt_d;
      end
   end

   assign tick       = tick_q;
   assign tick_count = tcnt_q;

endmodule

// File: rtl/clk_rate_ctrl.sv
// Clock-enable rate controller: selectable tick rate with req/ack rate
// changes applied only on a period boundary so no period is truncated.
module clk_rate_ctrl
   import clk_rate_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned CNT_W  = 6,
   parameter int unsigned TCNT_W = 16
) (
   input logic            clk_in,
   input logic            rst,
   clk_rate_ctrl_if.slave bus
);

   state_t     state_q, state_d;
   rate_code_t pend_q, pend_d;
   rate_code_t rate_q, rate_d;
   logic       busy_q, busy_d;
   logic       ack_q, ack_d;
   logic       load;
   logic       at_end;
   logic [CNT_W-1:0] div_m1;

   assign div_m1 = CNT_W'(div_of(rate_q));

   tick_gen #(
      .CNT_W  (CNT_W),
      .TCNT_W (TCNT_W)
   ) u_tick_gen (
      .clk_in     (clk_in),
      .rst        (rst),
      .en         (bus.en),
      .load       (load),
      .div_m1     (div_m1),
      .at_end     (at_end),
      .tick       (bus.tick),
      .tick_count (bus.tick_count)
   );

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      rate_d  = rate_q;
      busy_d  = busy_q;
      ack_d   = 1'b0;
      load    = 1'b0;
      unique case (state_q)
         RUN: begin
            if (bus.sel_req && !busy_q) begin
               pend_d  = bus.sel_code;
               busy_d  = 1'b1;
               state_d = PEND;
            end
         end
         PEND: begin
            // Switch on the edge that emits the last old-rate tick.
            if (at_end) begin
               rate_d  = pend_q;
               busy_d  = 1'b0;
               ack_d   = 1'b1;
               load    = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= RUN;
         pend_q  <= RATE_1M;
         rate_q  <= RATE_1M;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         rate_q  <= rate_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.sel_ack   = ack_q;
   assign bus.busy      = busy_q;
   assign bus.rate_code = rate_q;

   // Every rate must divide the input clock exactly.
   a_clk_divisible : assert property (@(posedge clk_in) (CLK_HZ % 50) == 0);
   a_ack_with_tick : assert property (@(posedge clk_in) disable iff (rst) ack_q |-> bus.tick);

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Directed bench for clk_rate_ctrl: rate table, handshake, enable stretch,
// reset during a pending change and tick counter wrap.
module tb_clk_rate_ctrl;
   import clk_rate_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;
   int   acks;
   int   first;

   clk_rate_ctrl_if #(.TCNT_W(16)) bus ();

   clk_rate_ctrl #(
      .CLK_HZ (50_000_000),
      .CNT_W  (6),
      .TCNT_W (16)
   ) dut (
      .clk_in (clk),
      .rst    (rst),
      .bus    (bus)
   );

   always #10 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.en = 1'b0;
      bus.sel_req = 1'b0;
      bus.sel_code = RATE_1M;
      cyc(2);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_tick", 32'(bus.tick), 0);
      chk("rst_tcnt", 32'(bus.tick_count), 0);
      chk("rst_rate", 32'(bus.rate_code), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_ack", 32'(bus.sel_ack), 0);

      // Rate 0: ticks at 50, 100, 150
      bus.en = 1'b1;
      cyc(49);
      chk("r0_no_tick49", 32'(bus.tick), 0);
      cyc(1);
      chk("r0_tick50", 32'(bus.tick), 1);
      cyc(50);
      chk("r0_tick100", 32'(bus.tick), 1);
      cyc(50);
      chk("r0_tick150", 32'(bus.tick), 1);
      cyc(1);
      chk("r0_tcnt151", 32'(bus.tick_count), 3);
      chk("r0_tick151", 32'(bus.tick), 0);
      chk("r0_rate", 32'(bus.rate_code), 0);
      chk("r0_busy", 32'(bus.busy), 0);

      // Request code 1 at cycle 20, ack at 50, then ticks every 5
      do_reset();
      bus.en = 1'b1;
      cyc(19);
      bus.sel_req = 1'b1;
      bus.sel_code = RATE_10M;
      cyc(1);
      bus.sel_req = 1'b0;
      chk("c1_busy_set", 32'(bus.busy), 1);
      cyc(29);
      chk("c1_busy49", 32'(bus.busy), 1);
      chk("c1_ack49", 32'(bus.sel_ack), 0);
      cyc(1);
      chk("c1_ack50", 32'(bus.sel_ack), 1);
      chk("c1_tick50", 32'(bus.tick), 1);
      chk("c1_busy50", 32'(bus.busy), 0);
      chk("c1_rate50", 32'(bus.rate_code), 1);
      cyc(1);
      chk("c1_ack_clr", 32'(bus.sel_ack), 0);
      cyc(3);
      chk("c1_no_tick54", 32'(bus.tick), 0);
      cyc(1);
      chk("c1_tick55", 32'(bus.tick), 1);
      cyc(5);
      chk("c1_tick60", 32'(bus.tick), 1);
      chk("c1_tcnt60", 32'(bus.tick_count), 3);
      cyc(5);
      chk("c1_tick65", 32'(bus.tick), 1);

      // Code 3 request, second request while busy is dropped
      bus.sel_req = 1'b1;
      bus.sel_code = RATE_50M;
      cyc(1);
      bus.sel_code = RATE_1M;
      cyc(1);
      bus.sel_req = 1'b0;
      cyc(2);
      chk("c3_busy69", 32'(bus.busy), 1);
      chk("c3_ack69", 32'(bus.sel_ack), 0);
      cyc(1);
      chk("c3_ack70", 32'(bus.sel_ack), 1);
      chk("c3_rate70", 32'(bus.rate_code), 3);
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("c3_tick_every", 32'(bus.tick), 1);
         acks += int'(bus.sel_ack);
      end
      chk("c3_no_second_ack", 32'(acks), 0);
      chk("c3_rate_kept", 32'(bus.rate_code), 3);
      chk("c3_tcnt", 32'(bus.tick_count), 15);

      // Move to code 2, then stretch a period with en=0 and a pending request
      bus.sel_req = 1'b1;
      bus.sel_code = RATE_25M;
      cyc(1);
      bus.sel_req = 1'b0;
      cyc(1);
      chk("c2_ack", 32'(bus.sel_ack), 1);
      chk("c2_rate", 32'(bus.rate_code), 2);
      cyc(1);
      chk("c2_mid_tick", 32'(bus.tick), 0);
      bus.en = 1'b0;
      bus.sel_req = 1'b1;
      bus.sel_code = RATE_1M;
      cyc(1);
      bus.sel_req = 1'b0;
      chk("dis_busy", 32'(bus.busy), 1);
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         chk("dis_no_tick", 32'(bus.tick), 0);
         acks += int'(bus.sel_ack);
      end
      chk("dis_no_ack", 32'(acks), 0);
      bus.en = 1'b1;
      cyc(1);
      chk("dis_tick_after", 32'(bus.tick), 1);
      chk("dis_ack_after", 32'(bus.sel_ack), 1);
      chk("dis_rate0", 32'(bus.rate_code), 0);
      chk("dis_tcnt", 32'(bus.tick_count), 18);

      // Reset while a change is pending
      bus.sel_req = 1'b1;
      bus.sel_code = RATE_10M;
      cyc(1);
      bus.sel_req = 1'b0;
      chk("rp_busy", 32'(bus.busy), 1);
      cyc(5);
      rst = 1'b1;
      cyc(1);
      chk("rp_rate", 32'(bus.rate_code), 0);
      chk("rp_busy_clr", 32'(bus.busy), 0);
      chk("rp_tcnt", 32'(bus.tick_count), 0);
      chk("rp_tick", 32'(bus.tick), 0);
      rst = 1'b0;
      acks = 0;
      first = 0;
      for (int i = 1; i <= 60; i++) begin
         cyc(1);
         if (bus.tick && first == 0) first = i;
         acks += int'(bus.sel_ack);
      end
      chk("rp_first_tick", 32'(first), 50);
      chk("rp_no_ack", 32'(acks), 0);
      chk("rp_rate_after", 32'(bus.rate_code), 0);

      // Rate 3 wrap of the tick counter
      do_reset();
      bus.en = 1'b1;
      bus.sel_req = 1'b1;
      bus.sel_code = RATE_50M;
      cyc(1);
      bus.sel_req = 1'b0;
      cyc(49);
      chk("wr_ack", 32'(bus.sel_ack), 1);
      chk("wr_tcnt1", 32'(bus.tick_count), 1);
      cyc(65535);
      chk("wr_tcnt_wrap", 32'(bus.tick_count), 0);
      chk("wr_tick", 32'(bus.tick), 1);
      chk("wr_rate", 32'(bus.rate_code), 3);
      chk("wr_busy", 32'(bus.busy), 0);
      chk("wr_ack_clr", 32'(bus.sel_ack), 0);
      cyc(1);
      chk("wr_tcnt_after", 32'(bus.tick_count), 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
